pitch_glide_control: RTL and testbench
======================================

# pitch_glide_control

Per-voice portamento engine for the synth engine pitch path. Holds a fixed-point current key and a target key for every voice. On each voice service slot of the time-multiplexed oscillator schedule, it steps the current key toward the target at a programmable rate. The resulting fractional key (Q8.FRAC semitones) feeds the constant-map / fine-tune stage in place of the raw 8-bit key.

## Interface
Parameters:
- VOICES, 8, number of voices
- V_WIDTH, 3, voice index width, clog2(VOICES)
- FRAC, 8, fractional key bits
- RATE_W, 7, glide rate width

Ports:
- sCLK_XVXOSC  in  1  engine clock; all state on rising edge
- reset_reg_N  in  1  asynchronous, active-low reset
- slot_valid  in  1  a voice service slot is present this cycle
- slot_voice  in  V_WIDTH  voice of current slot (voice field of the xxxx schedule index)
- note_on  in  1  single-cycle strobe: new note for note_voice
- note_off  in  1  single-cycle strobe: release note_voice
- note_voice  in  V_WIDTH  voice addressed by note_on/note_off
- note_key  in  8  MIDI key for note_on
- glide_rate  in  RATE_W  step per service, in 2^-FRAC semitone units; 0 = glide disabled
- glide_mode  in  2  0 off, 1 always, 2 legato, 3 treated as 1
- pitch_key  out  8+FRAC  glided key for pitch_voice, Q8.FRAC
- pitch_voice  out  V_WIDTH  voice of pitch_key
- pitch_valid  out  1  pitch_key/pitch_voice valid this cycle
- gliding  out  VOICES  bit v set while cur[v] != target of v

## Operation
- State per voice: tgt[v] (8 b), cur[v] (8+FRAC b), active[v] (1 b). T[v] = {tgt[v], FRAC'b0}.
- Reset values: tgt = 8'h40, cur = 8'h40<<FRAC, active = 0, pitch_key = 0, pitch_voice = 0, pitch_valid = 0, gliding = 0.
- note_on for voice v:
  - tgt[v] <= note_key and active[v] <= 1.
  - Jump (cur[v] <= {note_key, FRAC'b0}) when glide_mode == 0, or glide_rate == 0, or (glide_mode == 2 and active[v] == 0).
  - Otherwise cur[v] is unchanged and glide starts.
- note_off for voice v: active[v] <= 0. tgt and cur are unchanged, so glide continues through release.
- note_on and note_off in the same cycle: note_on wins. active is set.
- Slot service (slot_valid) for voice s, with d = T[s] - cur[s], treated as signed with width 9+FRAC:
  - |d| <= glide_rate, or glide_rate == 0: next = T[s].
  - d > 0: next = cur[s] + glide_rate.
  - d < 0: next = cur[s] - glide_rate.
  - Result: cur[s] <= next, pitch_key <= next, pitch_voice <= s, pitch_valid <= 1.
- The step never overshoots. Arithmetic never wraps; the output range is 0 to 255.996.
- Collision, note_on with note_voice == slot_voice in the same cycle:
  - The note_on update is applied; the step update is discarded.
  - pitch_key outputs the post-note_on cur (jump value or unchanged cur).
  - pitch_valid is still 1.
- A mid-glide note_on retargets from the current cur with no jump, except in the jump cases above.
- gliding[v] is registered: it reflects cur/tgt after the edge that updated them.
- glide_rate and glide_mode are sampled on every use and may change at any time. A change takes effect at the next service or note_on.

## Timing
- Service latency is 1 cycle: slot at edge n gives pitch_key/pitch_voice/pitch_valid valid after edge n, held for one cycle.
- pitch_valid is 0 in any cycle following a non-slot cycle.
- Back-to-back slots are allowed, including the same voice on consecutive cycles; each slot steps once.
- note_on/note_off take effect at the edge they are sampled.
- Asynchronous reset forces all state and outputs to reset values immediately. The first slot after deassertion is processed normally.

## Test plan
- Reset: assert reset_reg_N low mid-glide -> pitch_valid = 0, gliding = 0; after release, a slot for v3 gives pitch_key = 0x4000.
- Jump: glide_mode = 0, note_on v0 key 60, slot v0 -> pitch_key = 0x3C00, gliding[0] = 0.
- Glide up: note_on v1 key 60 in mode 0, then mode 1, rate 16, note_on v1 key 62 -> successive slots 0x3C10, 0x3C20, ...; 0x3E00 on the 32nd slot; gliding[1] clears; the 33rd slot holds 0x3E00.
- Non-overshoot down: cur 0x3E00, rate 100, note_on key 61 -> slots 0x3D9C, 0x3D38, 0x3D00 (clamped).
- Legato: mode 2, rate 16, v2 inactive, note_on key 50 -> jump to 0x3200. A second note_on key 52 while active -> glide. After note_off, note_on key 40 -> jump to 0x2800.
- Collision: slot v4 in the same cycle as note_on v4 key 70 with mode 0 -> pitch_key = 0x4600, pitch_voice = 4, pitch_valid = 1.

Source files
------------

// File: rtl/pitch_glide_control.sv
// Per-voice portamento: steps a fixed-point current key toward its target key
// on each voice service slot, at a programmable rate, without overshoot.
module pitch_glide_control #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int FRAC    = 8,
  parameter int RATE_W  = 7
) (
  input  logic                sCLK_XVXOSC,
  input  logic                reset_reg_N,
  input  logic                slot_valid,
  input  logic [V_WIDTH-1:0]  slot_voice,
  input  logic                note_on,
  input  logic                note_off,
  input  logic [V_WIDTH-1:0]  note_voice,
  input  logic [7:0]          note_key,
  input  logic [RATE_W-1:0]   glide_rate,
  input  logic [1:0]          glide_mode,
  output logic [8+FRAC-1:0]   pitch_key,
  output logic [V_WIDTH-1:0]  pitch_voice,
  output logic                pitch_valid,
  output logic [VOICES-1:0]   gliding
);

  localparam int KW = 8 + FRAC;
  localparam logic [7:0] RST_KEY = 8'h40;

  logic [7:0]        tgt_q   [VOICES];
  logic [KW-1:0]     cur_q   [VOICES];
  logic [VOICES-1:0] active_q;

  logic [7:0]        tgt_d   [VOICES];
  logic [KW-1:0]     cur_d   [VOICES];
  logic [VOICES-1:0] active_d;
  logic [VOICES-1:0] gliding_d;

  logic [KW-1:0] svc_cur;
  logic [KW-1:0] svc_tgt;
  logic [KW-1:0] step_next;
  logic [KW:0]   diff;
  logic [KW:0]   diff_mag;
  logic [KW:0]   rate_ext;
  logic          jump;
  logic [KW-1:0] pitch_key_d;

  // diff is one bit wider than the key so its MSB is the sign of tgt - cur
  always_comb begin
    svc_cur  = cur_q[slot_voice];
    svc_tgt  = {tgt_q[slot_voice], {FRAC{1'b0}}};
    diff     = {1'b0, svc_tgt} - {1'b0, svc_cur};
    diff_mag = diff[KW] ? (~diff + 1'b1) : diff;
    rate_ext = {{(KW+1-RATE_W){1'b0}}, glide_rate};
    if ((glide_rate == '0) || (diff_mag <= rate_ext))
      step_next = svc_tgt;
    else if (!diff[KW])
      step_next = svc_cur + rate_ext[KW-1:0];
    else
      step_next = svc_cur - rate_ext[KW-1:0];
  end

  assign jump = (glide_mode == 2'd0) || (glide_rate == '0) ||
                ((glide_mode == 2'd2) && !active_q[note_voice]);

  // note_on is applied last so it overrides both note_off and a colliding step
  always_comb begin
    active_d = active_q;
    for (int v = 0; v < VOICES; v++) begin
      tgt_d[v] = tgt_q[v];
      cur_d[v] = cur_q[v];
      if (slot_valid && (slot_voice == V_WIDTH'(v)))
        cur_d[v] = step_next;
      if (note_off && (note_voice == V_WIDTH'(v)))
        active_d[v] = 1'b0;
      if (note_on && (note_voice == V_WIDTH'(v))) begin
        tgt_d[v]    = note_key;
        active_d[v] = 1'b1;
        cur_d[v]    = jump ? {note_key, {FRAC{1'b0}}} : cur_q[v];
      end
      gliding_d[v] = (cur_d[v] != {tgt_d[v], {FRAC{1'b0}}});
    end
    pitch_key_d = cur_d[slot_voice];
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) begin
        tgt_q[v] <= RST_KEY;
        cur_q[v] <= {RST_KEY, {FRAC{1'b0}}};
      end
      active_q    <= '0;
      gliding     <= '0;
      pitch_key   <= '0;
      pitch_voice <= '0;
      pitch_valid <= 1'b0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        tgt_q[v] <= tgt_d[v];
        cur_q[v] <= cur_d[v];
      end
      active_q    <= active_d;
      gliding     <= gliding_d;
      pitch_valid <= slot_valid;
      if (slot_valid) begin
        pitch_key   <= pitch_key_d;
        pitch_voice <= slot_voice;
      end
    end
  end

endmodule

// File: tb/tb_pitch_glide_control.sv
// Directed-vector bench for pitch_glide_control with hand-computed expectations.
module tb_pitch_glide_control;

  logic        sCLK_XVXOSC = 1'b0;
  logic        reset_reg_N;
  logic        slot_valid;
  logic [2:0]  slot_voice;
  logic        note_on;
  logic        note_off;
  logic [2:0]  note_voice;
  logic [7:0]  note_key;
  logic [6:0]  glide_rate;
  logic [1:0]  glide_mode;
  logic [15:0] pitch_key;
  logic [2:0]  pitch_voice;
  logic        pitch_valid;
  logic [7:0]  gliding;

  int checks = 0;
  int errors = 0;

  pitch_glide_control dut (
    .sCLK_XVXOSC(sCLK_XVXOSC), .reset_reg_N(reset_reg_N),
    .slot_valid(slot_valid), .slot_voice(slot_voice),
    .note_on(note_on), .note_off(note_off), .note_voice(note_voice),
    .note_key(note_key), .glide_rate(glide_rate), .glide_mode(glide_mode),
    .pitch_key(pitch_key), .pitch_voice(pitch_voice),
    .pitch_valid(pitch_valid), .gliding(gliding)
  );

  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  task automatic tick();
    @(posedge sCLK_XVXOSC);
    #1;
  endtask

  task automatic note(input logic [2:0] v, input logic [7:0] key);
    note_on = 1'b1; note_voice = v; note_key = key;
    tick();
    note_on = 1'b0;
  endtask

  task automatic slot(input logic [2:0] v);
    slot_valid = 1'b1; slot_voice = v;
    tick();
    slot_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pitch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", pitch_valid); end
    checks++; if (pitch_key !== 16'h0) begin errors++; $display("FAIL rst_key: got %h expected 0000", pitch_key); end
    checks++; if (gliding !== 8'h00) begin errors++; $display("FAIL rst_gliding: got %h expected 00", gliding); end
    glide_mode = 2'd1; glide_rate = 7'd16;
    note(3'd5, 8'h50);
    checks++; if (gliding !== 8'h20) begin errors++; $display("FAIL rst_pre_gliding: got %h expected 20", gliding); end
    slot(3'd5);
    checks++; if (pitch_key !== 16'h4010) begin errors++; $display("FAIL rst_pre_step: got %h expected 4010", pitch_key); end
    reset_reg_N = 1'b0;
    #2;
    checks++; if (pitch_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b expected 0", pitch_valid); end
    checks++; if (gliding !== 8'h00) begin errors++; $display("FAIL rst_async_gliding: got %h expected 00", gliding); end
    @(negedge sCLK_XVXOSC);
    reset_reg_N = 1'b1;
    slot(3'd3);
    checks++; if (pitch_key !== 16'h4000) begin errors++; $display("FAIL rst_first_slot: got %h expected 4000", pitch_key); end
    checks++; if (pitch_voice !== 3'd3 || pitch_valid !== 1'b1) begin errors++; $display("FAIL rst_first_voice: got %0d/%0b expected 3/1", pitch_voice, pitch_valid); end
    tick();
    checks++; if (pitch_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %0b expected 0", pitch_valid); end
  endtask

  task automatic test_jump();
    glide_mode = 2'd0; glide_rate = 7'd16;
    note(3'd0, 8'd60);
    slot(3'd0);
    checks++; if (pitch_key !== 16'h3C00) begin errors++; $display("FAIL jump_key: got %h expected 3c00", pitch_key); end
    checks++; if (gliding[0] !== 1'b0) begin errors++; $display("FAIL jump_gliding: got %0b expected 0", gliding[0]); end
  endtask

  task automatic test_glide_up();
    logic [15:0] exp_key;
    glide_mode = 2'd0;
    note(3'd1, 8'd60);
    glide_mode = 2'd1; glide_rate = 7'd16;
    note(3'd1, 8'd62);
    checks++; if (gliding[1] !== 1'b1) begin errors++; $display("FAIL up_gliding_set: got %0b expected 1", gliding[1]); end
    for (int i = 1; i <= 32; i++) begin
      exp_key = 16'h3C00 + 16'(16 * i);
      slot(3'd1);
      checks++; if (pitch_key !== exp_key) begin errors++; $display("FAIL up_step%0d: got %h expected %h", i, pitch_key, exp_key); end
    end
    checks++; if (gliding[1] !== 1'b0) begin errors++; $display("FAIL up_gliding_clr: got %0b expected 0", gliding[1]); end
    slot(3'd1);
    checks++; if (pitch_key !== 16'h3E00) begin errors++; $display("FAIL up_hold: got %h expected 3e00", pitch_key); end
  endtask

  task automatic test_down_clamp();
    glide_mode = 2'd1; glide_rate = 7'd100;
    note(3'd1, 8'd61);
    slot(3'd1);
    checks++; if (pitch_key !== 16'h3D9C) begin errors++; $display("FAIL down1: got %h expected 3d9c", pitch_key); end
    slot(3'd1);
    checks++; if (pitch_key !== 16'h3D38) begin errors++; $display("FAIL down2: got %h expected 3d38", pitch_key); end
    slot(3'd1);
    checks++; if (pitch_key !== 16'h3D00) begin errors++; $display("FAIL down_clamp: got %h expected 3d00", pitch_key); end
  endtask

  task automatic test_legato();
    glide_mode = 2'd2; glide_rate = 7'd16;
    note(3'd2, 8'd50);
    slot(3'd2);
    checks++; if (pitch_key !== 16'h3200) begin errors++; $display("FAIL legato_first: got %h expected 3200", pitch_key); end
    note(3'd2, 8'd52);
    slot(3'd2);
    checks++; if (pitch_key !== 16'h3210) begin errors++; $display("FAIL legato_glide: got %h expected 3210", pitch_key); end
    note_off = 1'b1; note_voice = 3'd2;
    tick();
    note_off = 1'b0;
    checks++; if (gliding[2] !== 1'b1) begin errors++; $display("FAIL release_gliding: got %0b expected 1", gliding[2]); end
    note(3'd2, 8'd40);
    slot(3'd2);
    checks++; if (pitch_key !== 16'h2800) begin errors++; $display("FAIL legato_rejump: got %h expected 2800", pitch_key); end
    // simultaneous on/off leaves the voice active, so the next note glides
    note_off = 1'b1;
    note(3'd6, 8'd30);
    note_off = 1'b0;
    note(3'd6, 8'd32);
    slot(3'd6);
    checks++; if (pitch_key !== 16'h1E10) begin errors++; $display("FAIL on_off_same: got %h expected 1e10", pitch_key); end
  endtask

  task automatic test_collision();
    glide_mode = 2'd0; glide_rate = 7'd16;
    slot_valid = 1'b1; slot_voice = 3'd4;
    note(3'd4, 8'd70);
    slot_valid = 1'b0;
    checks++; if (pitch_key !== 16'h4600) begin errors++; $display("FAIL coll_key: got %h expected 4600", pitch_key); end
    checks++; if (pitch_voice !== 3'd4 || pitch_valid !== 1'b1) begin errors++; $display("FAIL coll_voice: got %0d/%0b expected 4/1", pitch_voice, pitch_valid); end
    glide_mode = 2'd1;
    slot_valid = 1'b1; slot_voice = 3'd4;
    note(3'd4, 8'd72);
    slot_valid = 1'b0;
    checks++; if (pitch_key !== 16'h4600) begin errors++; $display("FAIL coll_glide_key: got %h expected 4600", pitch_key); end
    checks++; if (gliding[4] !== 1'b1) begin errors++; $display("FAIL coll_gliding: got %0b expected 1", gliding[4]); end
  endtask

  task automatic test_back_to_back();
    slot_valid = 1'b1; slot_voice = 3'd4;
    tick();
    checks++; if (pitch_key !== 16'h4610) begin errors++; $display("FAIL b2b_1: got %h expected 4610", pitch_key); end
    tick();
    checks++; if (pitch_key !== 16'h4620) begin errors++; $display("FAIL b2b_2: got %h expected 4620", pitch_key); end
    slot_valid = 1'b0;
    tick();
    checks++; if (pitch_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b expected 0", pitch_valid); end
  endtask

  task automatic test_rate_zero_and_edges();
    glide_mode = 2'd3; glide_rate = 7'd16;
    note(3'd7, 8'h50);
    glide_rate = 7'd0;
    slot(3'd7);
    checks++; if (pitch_key !== 16'h5000) begin errors++; $display("FAIL rate0_snap: got %h expected 5000", pitch_key); end
    glide_mode = 2'd0;
    note(3'd7, 8'd255);
    glide_mode = 2'd1; glide_rate = 7'd127;
    note(3'd7, 8'd254);
    slot(3'd7);
    checks++; if (pitch_key !== 16'hFE81) begin errors++; $display("FAIL top1: got %h expected fe81", pitch_key); end
    slot(3'd7);
    checks++; if (pitch_key !== 16'hFE02) begin errors++; $display("FAIL top2: got %h expected fe02", pitch_key); end
    slot(3'd7);
    checks++; if (pitch_key !== 16'hFE00) begin errors++; $display("FAIL top_clamp: got %h expected fe00", pitch_key); end
  endtask

  initial begin
    reset_reg_N = 1'b0;
    slot_valid = 1'b0; slot_voice = '0;
    note_on = 1'b0; note_off = 1'b0; note_voice = '0; note_key = '0;
    glide_rate = '0; glide_mode = '0;
    #12;
    reset_reg_N = 1'b1;
    tick();
    test_reset();
    test_jump();
    test_glide_up();
    test_down_clamp();
    test_legato();
    test_collision();
    test_back_to_back();
    test_rate_zero_and_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
